// File: rtl/log_enc_pkg.sv
// Shared definitions for the Mitchell log encoder: k-width helper, stage-1 payload, pipeline depth.
package log_enc_pkg;

  localparam int PIPE_DEPTH = 2;

  // Payload fields are sized for the widest supported operand (64 bits); narrower
  // instances zero-extend into it and slice back out.
  localparam int MAX_W   = 64;
  localparam int MAX_K_W = 6;

  function automatic int k_width(input int width);
    return $clog2(width);
  endfunction

  typedef struct packed {
    logic [MAX_W-1:0]   data;
    logic [MAX_K_W-1:0] k;
    logic               zero;
  } s1_payload_t;

endpackage

// File: rtl/lod_pe.sv
// Combinational leading-one detector: position of the highest set bit plus an all-zero flag.
module lod_pe
  import log_enc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int K_W   = k_width(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  output logic [K_W-1:0]   k,
  output logic             zero
);

  // Scanning upward lets the highest set bit overwrite any lower ones.
  always_comb begin
    k    = '0;
    zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) begin
        k    = K_W'(i);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mitchell_log_enc.sv
// Two-stage Mitchell log encoder: stage 1 finds the leading one, stage 2 left-aligns the
// remaining bits into the fraction. Valid/ready on both sides with full backpressure.
module mitchell_log_enc
  import log_enc_pkg::*;
#(
  parameter int  WIDTH  = 16,
  parameter int  FRAC_W = 8,
  localparam int K_W    = k_width(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [K_W-1:0]    out_k,
  output logic [FRAC_W-1:0] out_frac,
  output logic              out_zero
);

  localparam int REM_W = WIDTH - 1;

  logic [K_W-1:0]    lod_k;
  logic              lod_zero;
  s1_payload_t       s1_d;
  s1_payload_t       s1_q;
  logic              s1_valid;
  logic              s2_valid;
  logic              s1_load;
  logic              s2_load;
  logic [WIDTH-1:0]  s1_data;
  logic [K_W-1:0]    s1_k;
  logic [K_W-1:0]    shamt;
  logic [WIDTH-1:0]  shifted;
  logic [REM_W-1:0]  rem;
  logic [FRAC_W-1:0] frac_d;
  logic              unused_bits;

  lod_pe #(
    .WIDTH (WIDTH),
    .K_W   (K_W)
  ) u_lod (
    .data (in_data),
    .k    (lod_k),
    .zero (lod_zero)
  );

  // A stage may load when it is empty or its contents move on this cycle.
  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = !rst && s1_load;
  assign out_valid = s2_valid;

  always_comb begin
    s1_d      = '0;
    s1_d.data = MAX_W'(in_data);
    s1_d.k    = MAX_K_W'(lod_k);
    s1_d.zero = lod_zero;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q <= s1_d;
      end
    end
  end

  // Shifting the leading one up to bit WIDTH-1 and dropping it leaves the
  // fraction bits left-aligned in the lower WIDTH-1 positions.
  assign s1_data = s1_q.data[WIDTH-1:0];
  assign s1_k    = s1_q.k[K_W-1:0];
  assign shamt   = K_W'(WIDTH - 1) - s1_k;
  assign shifted = s1_data << shamt;
  assign rem     = shifted[REM_W-1:0];

  generate
    if (FRAC_W <= REM_W) begin : g_trunc
      assign frac_d = rem[REM_W-1 -: FRAC_W];
    end else begin : g_pad
      assign frac_d = {rem, {(FRAC_W - REM_W){1'b0}}};
    end
  endgenerate

  // Upper payload bits and truncated remainder bits are intentionally dropped.
  assign unused_bits = ^{s1_q, shifted, rem};

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_k    <= '0;
      out_frac <= '0;
      out_zero <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_k    <= s1_k;
        out_frac <= frac_d;
        out_zero <= s1_q.zero;
      end
    end
  end

endmodule

// File: tb/tb_mitchell_log_enc.sv
// Scoreboard bench for mitchell_log_enc: directed vectors, stall, reset and a random stream.
module tb_mitchell_log_enc;

  localparam int WIDTH  = 16;
  localparam int FRAC_W = 8;
  localparam int K_W    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [K_W-1:0]    out_k;
  logic [FRAC_W-1:0] out_frac;
  logic              out_zero;

  typedef struct {
    int k;
    int frac;
    int zero;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   chk_lat = 1'b0;
  bit   seen_front = 1'b0;
  bit   done = 1'b0;

  mitchell_log_enc #(
    .WIDTH  (WIDTH),
    .FRAC_W (FRAC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_k     (out_k),
    .out_frac  (out_frac),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: k = floor(log2 x), frac = floor((x - 2^k) * 2^FRAC_W / 2^k).
  function automatic exp_t model(input logic [WIDTH-1:0] x);
    exp_t   e;
    int     i;
    longint d;
    i = WIDTH - 1;
    while (i > 0 && !x[i]) i--;
    e.k    = i;
    e.zero = (x == 0) ? 1 : 0;
    e.acc  = 0;
    if (x == 0) begin
      e.frac = 0;
    end else begin
      d      = longint'(x) - (longint'(1) << e.k);
      e.frac = int'((d << FRAC_W) >> e.k);
    end
    return e;
  endfunction

  // Called at posedge+1; presents one operand until accepted and logs the expectation.
  task automatic applyStimulus(input logic [WIDTH-1:0] x, input int ek, input int ef, input int ez);
    exp_t e;
    int   waitc;
    waitc    = 0;
    in_valid = 1'b1;
    in_data  = x;
    @(negedge clk);
    while (!in_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (in_ready) begin
      e.k    = ek;
      e.frac = ef;
      e.zero = ez;
      e.acc  = cyc;
      sb.push_back(e);
    end else begin
      checkOutput("in_ready_timeout", 32'(in_ready), 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 500) begin
      @(posedge clk);
      w++;
    end
    checkOutput("drain_empty", 32'(sb.size()), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: while a result is presented it must match the head of the scoreboard;
  // it is popped only when the transfer actually happens.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_out", 1, 0);
      end else begin
        if (chk_lat && !seen_front) checkOutput("latency", 32'(cyc - sb[0].acc), 2);
        seen_front = 1'b1;
        checkOutput("out_k", 32'(out_k), 32'(sb[0].k));
        checkOutput("out_frac", 32'(out_frac), 32'(sb[0].frac));
        checkOutput("out_zero", 32'(out_zero), 32'(sb[0].zero));
        if (out_ready) begin
          void'(sb.pop_front());
          seen_front = 1'b0;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] r;
    exp_t             e;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_out_k", 32'(out_k), 0);
    checkOutput("rst_out_frac", 32'(out_frac), 0);
    checkOutput("rst_out_zero", 32'(out_zero), 0);
    checkOutput("rst_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("release_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;

    $display("[TB] zero and one");
    chk_lat = 1'b1;
    applyStimulus(16'h0000, 0, 8'h00, 1);
    applyStimulus(16'h0001, 0, 8'h00, 0);
    drain();

    $display("[TB] directed operands");
    applyStimulus(16'hB000, 15, 8'h60, 0);
    applyStimulus(16'h0013,  4, 8'h30, 0);
    applyStimulus(16'hFFFF, 15, 8'hFF, 0);
    applyStimulus(16'h8000, 15, 8'h00, 0);
    drain();

    $display("[TB] walking one");
    for (int i = 0; i <= 8; i++) begin
      r = WIDTH'(1) << i;
      applyStimulus(r, i, 8'h00, 0);
    end
    drain();

    $display("[TB] backpressure");
    chk_lat   = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        applyStimulus(16'h0003, 1, 8'h80, 0);
        applyStimulus(16'h0005, 2, 8'h40, 0);
        applyStimulus(16'h00F0, 7, 8'hE0, 0);
        applyStimulus(16'h1234, 12, 8'h23, 0);
      end
      begin
        repeat (5) @(negedge clk);
        checkOutput("stall_in_ready", 32'(in_ready), 0);
        checkOutput("stall_accepted", 32'(sb.size()), 2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] random stream");
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 10000; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          r = WIDTH'($urandom_range(0, 65535) >> $urandom_range(0, 15));
          e = model(r);
          applyStimulus(r, e.k, e.frac, e.zero);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] reset with results in flight");
    out_ready = 1'b0;
    applyStimulus(16'h1234, 12, 8'h23, 0);
    applyStimulus(16'h0042, 6, 8'h08, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    checkOutput("midrst_out_valid", 32'(out_valid), 0);
    sb.delete();
    seen_front = 1'b0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    chk_lat   = 1'b1;
    applyStimulus(16'h0013, 4, 8'h30, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
